// File: rtl/noc_pkg.sv
// noc_pkg: flit/VC types shared by the router input stage
package noc_pkg;
    typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAINING} vc_state_t;
    localparam int FLIT_DATA_W = 32;
    typedef struct packed {
        flit_type_t                flit_type;
        logic [FLIT_DATA_W-1:0]    data;
    } flit_entry_t;
    // Type bit 0 marks a packet start, bit 1 a packet end
    function automatic logic is_head(input logic [1:0] t);
        return t[0];
    endfunction
    function automatic logic is_tail(input logic [1:0] t);
        return t[1];
    endfunction
endpackage

// File: rtl/input_vc_buffer_vc_fifo.sv
// vc_fifo: single-VC circular buffer with push, pop, count, full and empty
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 34,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        dout     = mem_q[rd_ptr_q];
        count    = cnt_q;
        full     = cnt_q == CW'(DEPTH);
        empty    = cnt_q == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-port VC buffers with packet FSMs, registered read port and credits
// Define INPUT_VC_BUFFER_ERR_EN to build the sticky protocol/overflow error flag.
module input_vc_buffer #(
    parameter int NUM_VC = 4,
    parameter int BUF_DEPTH = 4,
    parameter int FLIT_WIDTH = 32,
    parameter int VC_BITS = $clog2(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [VC_BITS-1:0]    in_vc,
    input  logic [1:0]            in_type,
    input  logic [FLIT_WIDTH-1:0] in_data,
    input  logic                  rd_en,
    input  logic [VC_BITS-1:0]    rd_vc,
    output logic                  out_valid,
    output logic [VC_BITS-1:0]    out_vc,
    output logic [1:0]            out_type,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic [NUM_VC-1:0]     vc_not_empty,
    output logic [NUM_VC-1:0]     vc_availability,
    output logic                  credit_valid,
    output logic [VC_BITS-1:0]    credit_vc,
    output logic                  error
);
    import noc_pkg::*;
    localparam int EW = FLIT_WIDTH + 2;
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    logic [EW-1:0]        head [NUM_VC];
    logic [CW-1:0]        cnt [NUM_VC];
    logic [NUM_VC-1:0]    full, empty, wr_sel, rd_sel;
    vc_state_t            state_q [NUM_VC];
    vc_state_t            state_d [NUM_VC];
    logic                 in_vc_ok, rd_vc_ok, rd_ok, wr_ok, type_ok, slot_ok;
    logic                 out_valid_q, out_valid_d;
    logic [VC_BITS-1:0]   out_vc_q, out_vc_d;
    logic [EW-1:0]        out_ent_q, out_ent_d;
    always_comb begin
        in_vc_ok = {1'b0, in_vc} < (VC_BITS+1)'(NUM_VC);
        rd_vc_ok = {1'b0, rd_vc} < (VC_BITS+1)'(NUM_VC);
        rd_ok    = rd_en && rd_vc_ok && !empty[rd_vc];
        type_ok  = is_head(in_type) ? state_q[in_vc] == IDLE : state_q[in_vc] == ACTIVE;
        // A same-cycle pop on the target VC frees the slot the push needs
        slot_ok  = !full[in_vc] || (rd_ok && rd_vc == in_vc);
        wr_ok    = in_valid && in_vc_ok && type_ok && slot_ok;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v] = wr_ok && in_vc == VC_BITS'(v);
            rd_sel[v] = rd_ok && rd_vc == VC_BITS'(v);
            state_d[v] = (state_q[v] == IDLE && wr_sel[v]) ? (is_tail(in_type) ? DRAINING : ACTIVE)
                       : (state_q[v] == ACTIVE && wr_sel[v] && is_tail(in_type)) ? DRAINING
                       : (state_q[v] == DRAINING && rd_sel[v] && is_tail(head[v][EW-1 -: 2])
                          && cnt[v] == CW'(1)) ? IDLE
                       : state_q[v];
            vc_availability[v] = state_q[v] == IDLE;
        end
        out_valid_d     = rd_ok;
        out_vc_d        = rd_ok ? rd_vc : out_vc_q;
        out_ent_d       = rd_ok ? head[rd_vc] : out_ent_q;
        out_valid       = out_valid_q;
        out_vc          = out_vc_q;
        out_type        = out_ent_q[EW-1 -: 2];
        out_data        = out_ent_q[FLIT_WIDTH-1:0];
        credit_valid    = out_valid_q;
        credit_vc       = out_vc_q;
        vc_not_empty    = ~empty;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_ent_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_vc_q    <= out_vc_d;
            out_ent_q   <= out_ent_d;
        end
        for (int v = 0; v < NUM_VC; v++) state_q[v] <= rst ? IDLE : state_d[v];
    end
    genvar g;
    generate
        for (g = 0; g < NUM_VC; g++) begin : g_vc
            vc_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (wr_sel[g]),
                .pop   (rd_sel[g]),
                .din   ({in_type, in_data}),
                .dout  (head[g]),
                .count (cnt[g]),
                .full  (full[g]),
                .empty (empty[g])
            );
        end
    endgenerate
`ifdef INPUT_VC_BUFFER_ERR_EN
    logic err_q, err_d;
    always_comb err_d = err_q | (in_valid && !wr_ok) | (rd_en && !rd_ok);
    always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_input_vc_buffer.sv
// tb_input_vc_buffer: scoreboard bench with a per-VC queue/state reference model
module tb_input_vc_buffer;
    import noc_pkg::*;
    localparam int NV = 4;
    localparam int D = 4;
    localparam int FW = 32;
`ifdef INPUT_VC_BUFFER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic          clk, rst, in_valid, rd_en;
    logic [1:0]    in_vc, in_type, rd_vc;
    logic [FW-1:0] in_data;
    logic          out_valid, credit_valid, error;
    logic [1:0]    out_vc, out_type, credit_vc;
    logic [FW-1:0] out_data;
    logic [NV-1:0] vc_not_empty, vc_availability;

    input_vc_buffer #(.NUM_VC(NV), .BUF_DEPTH(D), .FLIT_WIDTH(FW), .VC_BITS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vc(in_vc), .in_type(in_type),
        .in_data(in_data), .rd_en(rd_en), .rd_vc(rd_vc), .out_valid(out_valid),
        .out_vc(out_vc), .out_type(out_type), .out_data(out_data),
        .vc_not_empty(vc_not_empty), .vc_availability(vc_availability),
        .credit_valid(credit_valid), .credit_vc(credit_vc), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [33:0] mq [NV][$];
    vc_state_t   mst [NV];
    bit          merr;
    logic [35:0] sb [$];
    logic [35:0] me;
    bit          mon_en = 1'b0;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            mst[v] = IDLE;
        end
        merr = 1'b0;
        sb.delete();
    endtask

    task automatic check_status();
        logic [NV-1:0] ne, av;
        for (int v = 0; v < NV; v++) begin
            ne[v] = mq[v].size() > 0;
            av[v] = mst[v] == IDLE;
        end
        chk("vc_not_empty", vc_not_empty, ne);
        chk("vc_availability", vc_availability, av);
        chk("error", error, ERR_EN & merr);
    endtask

    task automatic step(input bit wv, input int wvc, input logic [1:0] t, input logic [31:0] d,
                        input bit re, input int rvc);
        bit rok, wok, tok, sok;
        logic [33:0] e;
        in_valid = wv; in_vc = wvc[1:0]; in_type = t; in_data = d;
        rd_en = re; rd_vc = rvc[1:0];
        rok = re && mq[rvc].size() > 0;
        tok = (t == HEAD || t == HEAD_TAIL) ? mst[wvc] == IDLE : mst[wvc] == ACTIVE;
        sok = mq[wvc].size() < D || (rok && rvc == wvc);
        wok = wv && tok && sok;
        e = '0;
        if (rok) begin
            e = mq[rvc].pop_front();
            if (mst[rvc] == DRAINING && (e[33:32] == TAIL || e[33:32] == HEAD_TAIL) && mq[rvc].size() == 0)
                mst[rvc] = IDLE;
        end
        if (wok) begin
            mq[wvc].push_back({t, d});
            if (t == HEAD) mst[wvc] = ACTIVE;
            else if (t == HEAD_TAIL || t == TAIL) mst[wvc] = DRAINING;
        end
        if ((wv && !wok) || (re && !rok)) merr = 1'b1;
        @(posedge clk);
        #1;
        if (rok) sb.push_back({rvc[1:0], e});
        in_valid = 1'b0;
        rd_en = 1'b0;
        check_status();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vc", out_vc, 0);
        chk("rst_out_type", out_type, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_credit_valid", credit_valid, 0);
        chk("rst_credit_vc", credit_vc, 0);
        check_status();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("out_valid", out_valid, 1);
                chk("out_vc", out_vc, me[35:34]);
                chk("out_type", out_type, me[33:32]);
                chk("out_data", out_data, me[31:0]);
                chk("credit_valid", credit_valid, 1);
                chk("credit_vc", credit_vc, me[35:34]);
            end else begin
                chk("idle_out_valid", out_valid, 0);
                chk("idle_credit", credit_valid, 0);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; rd_en = 1'b0;
        in_vc = '0; in_type = '0; in_data = '0; rd_vc = '0;
        do_reset();
        mon_en = 1'b1;
        step(1, 2, HEAD, 32'hA1, 0, 0);
        step(1, 2, BODY, 32'hA2, 0, 0);
        step(1, 2, TAIL, 32'hA3, 0, 0);
        repeat (3) step(0, 0, BODY, 0, 1, 2);
        step(0, 0, BODY, 0, 0, 0);
        step(1, 0, HEAD_TAIL, 32'h55, 0, 0);
        step(0, 0, BODY, 0, 1, 0);
        step(0, 0, BODY, 0, 0, 0);
        step(1, 1, HEAD, 32'h10, 0, 0);
        step(1, 1, BODY, 32'h11, 0, 0);
        step(1, 1, BODY, 32'h12, 0, 0);
        step(1, 1, BODY, 32'h13, 0, 0);
        step(1, 1, BODY, 32'h14, 0, 0);
        step(1, 1, BODY, 32'h15, 1, 1);
        step(1, 1, TAIL, 32'h16, 1, 1);
        repeat (5) step(0, 0, BODY, 0, 1, 1);
        step(1, 3, BODY, 32'h30, 0, 0);
        step(1, 1, HEAD, 32'h40, 0, 0);
        step(1, 1, HEAD, 32'h41, 0, 0);
        do_reset();
        step(1, 0, HEAD, 32'h100, 0, 0);
        step(1, 3, HEAD, 32'h300, 0, 0);
        step(1, 0, BODY, 32'h101, 1, 0);
        step(1, 3, BODY, 32'h301, 1, 3);
        step(1, 0, TAIL, 32'h102, 1, 0);
        step(1, 3, TAIL, 32'h302, 1, 3);
        step(0, 0, BODY, 0, 1, 0);
        step(0, 0, BODY, 0, 1, 3);
        step(0, 0, BODY, 0, 0, 0);
        step(1, 1, HEAD, 32'h20, 0, 0);
        step(1, 1, BODY, 32'h21, 0, 0);
        do_reset();
        step(0, 0, BODY, 0, 0, 0);
        repeat (300)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        repeat (2) step(0, 0, BODY, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
